// File: rtl/core_pkg.sv
// Shared fetch-path definitions: fault codes, the response record and the fault decoder.
package core_pkg;

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  fault;
  } fetch_rsp_t;

  // Misalignment wins over range; any PC bit above the word index means out of range.
  function automatic logic [1:0] decode_fault(input logic [31:0] pc, input int idx_w);
    if (pc[1:0] != 2'b00) return FAULT_MISALIGN;
    if ((pc >> (idx_w + 2)) != 32'd0) return FAULT_RANGE;
    return FAULT_OK;
  endfunction

endpackage

// File: rtl/imem_sram_1r1w.sv
// DEPTH x DATA_W instruction array: one registered read port, one write port, read-before-write.
module imem_sram_1r1w #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the read register is reset; it is loaded solely on rd_en so a captured word stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/instruction_memory_pipelined.sv
// Pipelined instruction fetch store: request/response handshakes, fault decode and READ_LAT stage registers.
module instruction_memory_pipelined
  import core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 256,
  parameter int READ_LAT = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [31:0]       rsp_pc,
  output logic [1:0]        rsp_fault,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // valid never waits on ready; once rsp_valid is up, rsp_* hold until the consumer takes them.

  logic [IDX_W-1:0]  req_idx;
  logic [1:0]        req_fault;
  logic              accept;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;

  logic              s1_valid;
  logic [31:0]       s1_pc;
  logic [1:0]        s1_fault;
  logic              s1_adv;

  assign req_idx   = req_pc[IDX_W+1:2];
  assign req_fault = decode_fault(req_pc, IDX_W);
  // A flush empties every stage this edge, so the redirect target can always enter.
  assign req_ready = s1_adv || flush;
  assign accept    = req_valid && req_ready;
  assign rd_en     = accept && (req_fault == FAULT_OK);

  imem_sram_1r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_sram (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (rd_en),
    .rd_addr (req_idx),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_pc    <= '0;
      s1_fault <= FAULT_OK;
    end else begin
      if (flush || s1_adv) s1_valid <= accept;
      if (accept) begin
        s1_pc    <= req_pc;
        s1_fault <= req_fault;
      end
    end
  end

  if (READ_LAT == 1) begin : g_lat1
    // The array read register is the data field of the single stage.
    assign s1_adv    = !s1_valid || rsp_ready;
    assign rsp_valid = s1_valid;
    assign rsp_pc    = s1_pc;
    assign rsp_fault = s1_fault;
    assign rsp_instr = (s1_fault == FAULT_OK) ? rd_data : NOP_WORD;
  end else begin : g_lat2
    logic              s2_valid;
    logic [31:0]       s2_pc;
    logic [1:0]        s2_fault;
    logic [DATA_W-1:0] s2_data;
    logic              s2_adv;

    assign s2_adv = !s2_valid || rsp_ready;
    assign s1_adv = !s1_valid || s2_adv;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid <= 1'b0;
        s2_pc    <= '0;
        s2_fault <= FAULT_OK;
        s2_data  <= '0;
      end else begin
        if (flush) s2_valid <= 1'b0;
        else if (s2_adv) s2_valid <= s1_valid;
        if (!flush && s2_adv && s1_valid) begin
          s2_pc    <= s1_pc;
          s2_fault <= s1_fault;
          s2_data  <= rd_data;
        end
      end
    end

    assign rsp_valid = s2_valid;
    assign rsp_pc    = s2_pc;
    assign rsp_fault = s2_fault;
    assign rsp_instr = (s2_fault == FAULT_OK) ? s2_data : NOP_WORD;
  end

endmodule
